bin_to_bcd_seq: RTL and testbench

//  Sequential double-dabble converter: binary switch value -> packed BCD nibbles.

---
 rtl/bin_to_bcd_seq_pkg.sv | 14 +
 rtl/bin_to_bcd_seq_if.sv | 28 ++
 rtl/bin_to_bcd_seq_digit_adj.sv | 18 +
 rtl/bin_to_bcd_seq.sv | 118 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/bin_to_bcd_seq_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding and BCD digit constants.
package bin_to_bcd_seq_pkg;

    localparam int BCD_DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/bin_to_bcd_seq_if.sv
// Request/result bundle between the switch logic and the BCD converter.
// The slave side is the converter, the master side is whoever feeds it.
interface bin_to_bcd_seq_if
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 8
);

    logic [BIN_W-1:0]              bin_in;
    logic                          start;
    logic                          auto_en;
    logic                          busy;
    logic                          done;
    logic [BCD_DIGIT_W*DIGITS-1:0] bcd_out;
    logic [DIGITS-1:0]             lz_mask;

    modport master (
        output bin_in, start, auto_en,
        input  busy, done, bcd_out, lz_mask
    );

    modport slave (
        input  bin_in, start, auto_en,
        output busy, done, bcd_out, lz_mask
    );

endinterface

// File: rtl/bin_to_bcd_seq_digit_adj.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more,
// so the following left shift carries correctly into the next digit.
module bin_to_bcd_seq_digit_adj
    import bin_to_bcd_seq_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    // Inputs never exceed 9 here, so the 4-bit sum cannot overflow.
    always_comb begin
        digit_out = digit_in;
        if (digit_in >= BCD_DIGIT_W'(ADD3_THRESH)) begin
            digit_out = digit_in + BCD_DIGIT_W'(3);
        end
    end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, publishes packed BCD
// digits and a leading-zero blanking mask for the seven-segment display.
module bin_to_bcd_seq
    import bin_to_bcd_seq_pkg::*;
#(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 8
) (
    input  logic             clk,
    input  logic             rst,
    bin_to_bcd_seq_if.slave  bus
);

    localparam int BCD_W = BCD_DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [DIGITS-1:0] LZ_RST = {{(DIGITS-1){1'b1}}, 1'b0};

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   latched_q, latched_d;
    logic [BIN_W-1:0]   shreg_q, shreg_d;
    logic [BCD_W-1:0]   scratch_q, scratch_d;
    logic [BCD_W-1:0]   scratch_adj;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic [DIGITS-1:0]  lz_q, lz_d;
    logic               done_q, done_d;
    logic               trigger;

    // Bit i is set when digit i and every digit above it are zero; digit 0 always shows.
    function automatic logic [DIGITS-1:0] lz_of(input logic [BCD_W-1:0] v);
        logic [DIGITS-1:0] m;
        logic              all_zero;
        m        = '0;
        all_zero = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero && (v[i*BCD_DIGIT_W +: BCD_DIGIT_W] == '0);
            m[i]     = all_zero;
        end
        return m;
    endfunction

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bin_to_bcd_seq_digit_adj u_adj (
            .digit_in  (scratch_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (scratch_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    assign trigger = bus.start || (bus.auto_en && (bus.bin_in != latched_q));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        latched_d = latched_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        bcd_d     = bcd_q;
        lz_d      = lz_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    latched_d = bus.bin_in;
                    shreg_d   = bus.bin_in;
                    scratch_d = '0;
                    cnt_d     = CNT_W'(BIN_W);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                {scratch_d, shreg_d} = {scratch_adj, shreg_q} << 1;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_d   = scratch_q;
                lz_d    = lz_of(scratch_q);
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            latched_q <= '0;
            bcd_q     <= '0;
            lz_q      <= LZ_RST;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            latched_q <= latched_d;
            bcd_q     <= bcd_d;
            lz_q      <= lz_d;
            done_q    <= done_d;
        end
    end

    // Working registers are always reloaded on a trigger, so they carry no reset.
    always_ff @(posedge clk) begin
        shreg_q   <= shreg_d;
        scratch_q <= scratch_d;
    end

    assign bus.busy    = (state_q != ST_IDLE);
    assign bus.done    = done_q;
    assign bus.bcd_out = bcd_q;
    assign bus.lz_mask = lz_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: directed scenarios plus randomized conversions
// checked against a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bin_to_bcd_seq_if #(.BIN_W(16), .DIGITS(8)) bus ();

    bin_to_bcd_seq #(.BIN_W(16), .DIGITS(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_lz(input int unsigned v);
        logic [7:0]  m;
        int unsigned p;
        m = '0;
        p = 10;
        for (int i = 1; i < 8; i++) begin
            m[i] = (v < p);
            p = p * 10;
        end
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_conv(input logic [15:0] v);
        bus.bin_in = v;
        bus.start  = 1'b1;
        step();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int cyc);
        cyc = 0;
        while (!bus.done && cyc < max_cyc) begin
            step();
            cyc++;
        end
        check("done_seen", 32'(bus.done), 32'd1);
    endtask

    task automatic conv_and_check(input logic [15:0] v, input string tag);
        int cyc;
        start_conv(v);
        check({tag, "_busy"}, 32'(bus.busy), 32'd1);
        wait_done(40, cyc);
        check({tag, "_lat"}, 32'(cyc), 32'd17);
        check({tag, "_bcd"}, bus.bcd_out, ref_bcd(32'(v)));
        check({tag, "_lz"}, 32'(bus.lz_mask), 32'(ref_lz(32'(v))));
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
        step();
        check({tag, "_pulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int          pulses;
        int          cyc;
        int          last;
        logic [31:0] seen;
        logic [15:0] v;

        checks      = 0;
        errors      = 0;
        rst         = 1'b1;
        bus.bin_in  = '0;
        bus.start   = 1'b0;
        bus.auto_en = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_bcd", bus.bcd_out, 32'h0);
        check("rst_lz", 32'(bus.lz_mask), 32'h0000_00FE);
        rst = 1'b0;
        step();

        conv_and_check(16'd0, "zero");
        check("zero_lz_const", 32'(bus.lz_mask), 32'h0000_00FE);
        conv_and_check(16'hFFFF, "max");
        check("max_bcd_const", bus.bcd_out, 32'h0006_5535);
        check("max_lz_const", 32'(bus.lz_mask), 32'h0000_00E0);

        // Second start and an input change mid-conversion must be ignored.
        start_conv(16'd9999);
        repeat (4) step();
        bus.start  = 1'b1;
        bus.bin_in = 16'd1;
        step();
        bus.start  = 1'b0;
        pulses = 0;
        seen   = '0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done) begin
                pulses++;
                seen = bus.bcd_out;
            end
        end
        check("restart_pulses", 32'(pulses), 32'd1);
        check("restart_bcd", seen, 32'h0000_9999);

        bus.bin_in  = 16'd42;
        bus.auto_en = 1'b1;
        wait_done(40, cyc);
        check("auto42_bcd", bus.bcd_out, 32'h0000_0042);
        step();
        bus.bin_in = 16'd1234;
        wait_done(40, cyc);
        check("auto1234_bcd", bus.bcd_out, 32'h0000_1234);
        check("auto1234_lz", 32'(bus.lz_mask), 32'h0000_00F0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) pulses++;
        end
        check("auto_steady", 32'(pulses), 32'd0);
        bus.auto_en = 1'b0;

        // Asynchronous reset in the middle of a conversion.
        start_conv(16'd500);
        repeat (7) step();
        #2 rst = 1'b1;
        #1;
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_bcd", bus.bcd_out, 32'h0);
        check("abort_lz", 32'(bus.lz_mask), 32'h0000_00FE);
        check("abort_done", 32'(bus.done), 32'd0);
        #1 rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bus.done) pulses++;
        end
        check("abort_nodone", 32'(pulses), 32'd0);
        check("abort_bcd_hold", bus.bcd_out, 32'h0);

        // Start held high: back-to-back conversions every 18 cycles.
        bus.bin_in = 16'd7;
        bus.start  = 1'b1;
        pulses = 0;
        last   = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (bus.done) begin
                pulses++;
                check("b2b_period", 32'(i - last), 32'd18);
                check("b2b_bcd", bus.bcd_out, 32'h0000_0007);
                last = i;
            end
        end
        check("b2b_pulses", 32'(pulses), 32'd4);
        bus.start = 1'b0;
        repeat (20) step();

        conv_and_check(16'd9, "edge9");
        conv_and_check(16'd10, "edge10");
        conv_and_check(16'd100, "edge100");
        conv_and_check(16'd10000, "edge10000");
        for (int n = 0; n < 250; n++) begin
            v = 16'($urandom);
            conv_and_check(v, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
